// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the front-panel hex entry controller.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        ST_EDIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    localparam int NIBBLE_W    = 4;
    localparam int NIBBLES_DEF = 32;
    localparam int TIMEOUT_DEF = 1_000_000;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/hex_entry_ctrl_wait_timer.sv
// Watchdog counter for the WAIT state: flags the last allowed cycle.
module wait_timer
    import hex_entry_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Clear wins over counting so a fresh WAIT always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/hex_entry_ctrl.sv
// Nibble-at-a-time block editor feeding the cipher core, with result capture
// and a watchdog on the core's completion.
module hex_entry_ctrl
    import hex_entry_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc_pulse,
    input  logic                          dec_pulse,
    input  logic                          next_pulse,
    input  logic                          go_pulse,
    output logic [NIBBLE_W*NIBBLES-1:0]   data_out,
    output logic [clog2(NIBBLES)-1:0]     cursor,
    output logic                          start_valid,
    input  logic                          start_ready,
    input  logic                          core_done,
    input  logic [NIBBLE_W*NIBBLES-1:0]   result_in,
    output logic [NIBBLE_W*NIBBLES-1:0]   result_out,
    output logic [1:0]                    state_out,
    output logic                          err
);

    localparam int               CUR_W    = clog2(NIBBLES);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NIBBLES - 1);

    state_t              state;
    logic [NIBBLE_W-1:0] cur_nib;
    logic                tmr_clear;
    logic                tmr_en;
    logic                tmr_expired;

    // Nibble currently under the cursor, source for inc/dec.
    always_comb begin
        cur_nib = data_out[int'(cursor)*NIBBLE_W +: NIBBLE_W];
    end

    // Timer restarts on the handshake edge and runs only while waiting.
    always_comb begin
        tmr_clear = (state == ST_ISSUE) && start_ready;
        tmr_en    = (state == ST_WAIT);
    end

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Control FSM and nibble datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EDIT;
            data_out    <= '0;
            cursor      <= '0;
            start_valid <= 1'b0;
            result_out  <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_EDIT: begin
                    // One action per cycle: go > next > inc > dec.
                    if (go_pulse) begin
                        err         <= 1'b0;
                        start_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end else if (next_pulse) begin
                        cursor <= (cursor == CUR_LAST) ? '0 : cursor + CUR_W'(1);
                    end else if (inc_pulse) begin
                        data_out[int'(cursor)*NIBBLE_W +: NIBBLE_W] <= cur_nib + NIBBLE_W'(1);
                    end else if (dec_pulse) begin
                        data_out[int'(cursor)*NIBBLE_W +: NIBBLE_W] <= cur_nib - NIBBLE_W'(1);
                    end
                end
                ST_ISSUE: begin
                    if (start_ready) begin
                        start_valid <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion on the final cycle still counts as success.
                    if (core_done) begin
                        result_out <= result_in;
                        state      <= ST_SHOW;
                    end else if (tmr_expired) begin
                        err   <= 1'b1;
                        state <= ST_EDIT;
                    end
                end
                ST_SHOW: begin
                    if (go_pulse) state <= ST_EDIT;
                end
                default: state <= ST_EDIT;
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Scoreboard bench for hex_entry_ctrl (NIBBLES=32, TIMEOUT=8).
module tb_hex_entry_ctrl;

    localparam int NIB = 32;
    localparam int TO  = 8;
    localparam logic [127:0] PATTERN = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;

    logic         clk;
    logic         rst;
    logic         inc_pulse, dec_pulse, next_pulse, go_pulse;
    logic [127:0] data_out;
    logic [4:0]   cursor;
    logic         start_valid;
    logic         start_ready;
    logic         core_done;
    logic [127:0] result_in;
    logic [127:0] result_out;
    logic [1:0]   state_out;
    logic         err;

    hex_entry_ctrl #(.NIBBLES(NIB), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .next_pulse  (next_pulse),
        .go_pulse    (go_pulse),
        .data_out    (data_out),
        .cursor      (cursor),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .core_done   (core_done),
        .result_in   (result_in),
        .result_out  (result_out),
        .state_out   (state_out),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        int           kind;
        logic [127:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   sv_cycles = 0;

    // Reference model state
    logic [127:0] m_data;
    logic [127:0] m_result;
    int           m_cursor;
    int           m_state;
    bit           m_sv;
    bit           m_err;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] observe(input int kind);
        case (kind)
            0:       return data_out;
            1:       return 128'(cursor);
            2:       return 128'(state_out);
            3:       return 128'(start_valid);
            4:       return result_out;
            default: return 128'(err);
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [127:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic push_all(input string tag);
        push($sformatf("%s.data", tag),   0, m_data);
        push($sformatf("%s.cursor", tag), 1, 128'(m_cursor));
        push($sformatf("%s.state", tag),  2, 128'(m_state));
        push($sformatf("%s.valid", tag),  3, 128'(m_sv));
        push($sformatf("%s.result", tag), 4, m_result);
        push($sformatf("%s.err", tag),    5, 128'(m_err));
    endtask

    task automatic compare_now();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic model_reset();
        m_data   = '0;
        m_result = '0;
        m_cursor = 0;
        m_state  = 0;
        m_sv     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
        next_pulse = 1'b0;
        go_pulse   = 1'b0;
        core_done  = 1'b0;
        if (start_valid) sv_cycles++;
        compare_now();
    endtask

    task automatic press(input string tag, input bit i, input bit d, input bit n, input bit g);
        inc_pulse  = i;
        dec_pulse  = d;
        next_pulse = n;
        go_pulse   = g;
        if (m_state == 0) begin
            if (g) begin
                m_err = 1'b0; m_sv = 1'b1; m_state = 1;
            end else if (n) begin
                m_cursor = (m_cursor == NIB - 1) ? 0 : m_cursor + 1;
            end else if (i) begin
                m_data[m_cursor*4 +: 4] = m_data[m_cursor*4 +: 4] + 4'd1;
            end else if (d) begin
                m_data[m_cursor*4 +: 4] = m_data[m_cursor*4 +: 4] - 4'd1;
            end
        end else if (m_state == 3 && g) begin
            m_state = 0;
        end
        push_all(tag);
        step();
    endtask

    // Asynchronous reset: outputs must return to reset values with no clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        push_all(tag);
        compare_now();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        inc_pulse = 0; dec_pulse = 0; next_pulse = 0; go_pulse = 0;
        start_ready = 0; core_done = 0; result_in = '0;
        model_reset();
        #3;
        push_all("reset");
        compare_now();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) press("inc", 1, 0, 0, 0);
        press("dec", 0, 1, 0, 0);
        chk("edit_02", data_out, 128'h2);
        for (int k = 0; k < 17; k++) press("inc_wrap", 1, 0, 0, 0);
        chk("wrap_up_03", data_out, 128'h3);

        do_reset("reset2");
        press("dec_wrap", 0, 1, 0, 0);
        chk("wrap_down_F", data_out, 128'hF);
        for (int k = 0; k < NIB; k++) begin
            press("next", 0, 0, 1, 0);
            if (k == NIB - 2) chk("cursor_last", 128'(cursor), 128'd31);
        end
        chk("cursor_wrap", 128'(cursor), 128'd0);

        press("inc_and_dec", 1, 1, 0, 0);
        chk("inc_beats_dec", data_out, 128'h0);

        result_in = '1;
        core_done = 1'b1;
        press("done_in_edit", 0, 0, 0, 0);

        sv_cycles = 0;
        press("go_and_inc", 1, 0, 0, 1);
        chk("go_beats_inc", data_out, 128'h0);
        for (int k = 0; k < 5; k++) begin
            push_all("issue_hold");
            step();
        end
        start_ready = 1'b1;
        m_state = 2;
        m_sv = 1'b0;
        push_all("handshake");
        step();
        start_ready = 1'b0;
        chk("valid_cycles", 128'(sv_cycles), 128'd6);

        for (int k = 0; k < 2; k++) begin
            push_all("wait_idle");
            step();
        end
        result_in = PATTERN;
        core_done = 1'b1;
        m_result  = PATTERN;
        m_state   = 3;
        push_all("done");
        step();
        chk("result_capture", result_out, PATTERN);
        chk("state_show", 128'(state_out), 128'd3);

        press("inc_in_show", 1, 0, 1, 0);
        press("go_to_edit", 0, 0, 0, 1);

        press("go_timeout", 0, 0, 0, 1);
        start_ready = 1'b1;
        m_state = 2;
        m_sv = 1'b0;
        push_all("hs_timeout");
        step();
        start_ready = 1'b0;
        for (int k = 1; k < TO; k++) begin
            push_all($sformatf("wait_%0d", k));
            step();
        end
        m_state = 0;
        m_err   = 1'b1;
        push_all("timeout");
        step();
        chk("err_set", 128'(err), 128'd1);

        press("go_clear_err", 0, 0, 0, 1);
        chk("err_clear", 128'(err), 128'd0);
        push_all("issue_pre_rst");
        step();
        do_reset("rst_in_issue");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
